// File: rtl/regbank_write_queue_pkg.sv
// Shared definitions for the register-bank write queue: default sizes,
// the hard-wired zero register index and the pending-entry layout.
package regbank_write_queue_pkg;

  localparam int DEF_DATA_LENGTH = 32;
  localparam int DEF_REGS_QTY    = 32;
  localparam int ZERO_REG        = 0;

  // Pending write as held in the queue for the default bank geometry.
  typedef struct packed {
    logic [$clog2(DEF_REGS_QTY)-1:0] addr;
    logic [DEF_DATA_LENGTH-1:0]      data;
  } pending_entry_t;

endpackage

// File: rtl/regbank_write_queue_onehot.sv
// Gated binary-to-one-hot decoder driving the register bank write enables.
module onehot_decoder_param #(
  parameter int ADDR_LENGTH = 5,
  parameter int REGS_QTY    = 32
) (
  input  logic                   i_en,
  input  logic [ADDR_LENGTH-1:0] i_addr,
  output logic [REGS_QTY-1:0]    o_onehot
);

  assign o_onehot = i_en ? (REGS_QTY'(1) << i_addr) : '0;

endmodule

// File: rtl/regbank_write_queue.sv
// In-order write-back queue in front of the register bank, retiring one
// request per cycle and exposing youngest-pending bypass lookups.
module regbank_write_queue
  import regbank_write_queue_pkg::*;
#(
  parameter  int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter  int REGS_QTY    = DEF_REGS_QTY,
  parameter  int DEPTH       = 4,
  localparam int ADDR_LENGTH = $clog2(REGS_QTY),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_LENGTH-1:0] wr_addr,
  input  logic [DATA_LENGTH-1:0] wr_data,
  input  logic                   hold,
  output logic [REGS_QTY-1:0]    en,
  output logic [DATA_LENGTH-1:0] d,
  input  logic [ADDR_LENGTH-1:0] rs1_addr,
  input  logic [ADDR_LENGTH-1:0] rs2_addr,
  output logic                   rs1_hit,
  output logic                   rs2_hit,
  output logic [DATA_LENGTH-1:0] rs1_data,
  output logic [DATA_LENGTH-1:0] rs2_data,
  output logic [CNT_W-1:0]       count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_LENGTH-1:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic   w_pop;
  logic   w_push;
  logic   w_empty;
  entry_t w_head;

  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_head];
  assign w_pop    = !w_empty && !hold;
  assign wr_ready = (r_count < CNT_W'(DEPTH)) || w_pop;
  // x0 writes complete the handshake but are dropped
  assign w_push   = wr_valid && wr_ready && (wr_addr != ADDR_LENGTH'(ZERO_REG));

  assign d     = w_pop ? w_head.data : '0;
  assign count = r_count;
  assign empty = w_empty;

  onehot_decoder_param #(
    .ADDR_LENGTH (ADDR_LENGTH),
    .REGS_QTY    (REGS_QTY)
  ) u_en_dec (
    .i_en     (w_pop),
    .i_addr   (w_head.addr),
    .o_onehot (en)
  );

  // Walk oldest to youngest so the last match wins.
  function automatic logic [DATA_LENGTH:0] f_lookup(input logic [ADDR_LENGTH-1:0] a);
    logic                   hit;
    logic [DATA_LENGTH-1:0] dat;
    logic [PTR_W-1:0]       idx;
    hit = 1'b0;
    dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (a != ADDR_LENGTH'(ZERO_REG)) && (r_mem[idx].addr == a)) begin
        hit = 1'b1;
        dat = r_mem[idx].data;
      end
    end
    return {hit, dat};
  endfunction

  always_comb begin
    {rs1_hit, rs1_data} = f_lookup(rs1_addr);
    {rs2_hit, rs2_data} = f_lookup(rs2_addr);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_write_queue.sv
// Self-checking bench: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regbank_write_queue;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        hold;
  logic [31:0] en;
  logic [31:0] d;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_hit, rs2_hit;
  logic [31:0] rs1_data, rs2_data;
  logic [2:0]  count;
  logic        empty;

  regbank_write_queue #(.DATA_LENGTH(32), .REGS_QTY(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold), .en(en), .d(d),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void look(input logic [4:0] a, output bit h, output logic [31:0] dt);
    h  = 0;
    dt = '0;
    if (a != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr == a) begin
          h  = 1;
          dt = q[i].data;
          break;
        end
      end
    end
  endfunction

  // Inputs are set just after a falling edge; this compares, advances the
  // model across the next rising edge, and returns after the falling edge.
  task automatic cycle();
    bit          pop, rdy, h1, h2;
    logic [31:0] e_en, e_d, d1, d2;
    #1;
    pop  = (q.size() > 0) && !hold;
    rdy  = (q.size() < 4) || pop;
    e_en = pop ? (32'h1 << q[0].addr) : 32'h0;
    e_d  = pop ? q[0].data : 32'h0;
    look(rs1_addr, h1, d1);
    look(rs2_addr, h2, d2);
    if (model_on) begin
      chk("en", en, e_en);
      chk("d", d, e_d);
      chk("wr_ready", wr_ready, rdy);
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("rs1_hit", rs1_hit, h1);
      chk("rs1_data", rs1_data, d1);
      chk("rs2_hit", rs2_hit, h2);
      chk("rs2_data", rs2_data, d2);
    end
    if (rst) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (wr_valid && rdy && wr_addr != 0) q.push_back('{wr_addr, wr_data});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] dt);
    wr_valid = 1; wr_addr = a; wr_data = dt;
    cycle();
    wr_valid = 0;
  endtask

  initial begin
    rst = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; hold = 0;
    rs1_addr = 0; rs2_addr = 0;
    @(negedge clk);
    rst = 1;
    cycle();
    rst = 0;
    model_on = 1;

    // reset state
    rs1_addr = 5; rs2_addr = 9;
    #1;
    chk("rst_en", en, 0);
    chk("rst_d", d, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", wr_ready, 1);
    chk("rst_hit", rs1_hit, 0);

    // single write retires one cycle after acceptance
    push(5, 32'hDEADBEEF);
    #1;
    chk("t1_en", en, 32'h20);
    chk("t1_d", d, 32'hDEADBEEF);
    chk("t1_hit", rs1_hit, 1);
    cycle();
    #1;
    chk("t1_en_after", en, 0);
    chk("t1_empty", empty, 1);

    // fill under hold, then drain in order
    hold = 1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h11 * i);
    wr_valid = 1; wr_addr = 6; wr_data = 32'h66;
    #1;
    chk("t2_count", count, 4);
    chk("t2_ready", wr_ready, 0);
    chk("t2_en", en, 0);
    cycle();
    wr_valid = 0;
    hold = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_drain_en", en, 32'h1 << i);
      chk("t2_drain_d", d, 32'h11 * i);
      cycle();
    end
    #1;
    chk("t2_empty", empty, 1);

    // push into a full queue while popping
    hold = 1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h11 * i);
    hold = 0;
    wr_valid = 1; wr_addr = 7; wr_data = 32'h77;
    #1;
    chk("t3_ready", wr_ready, 1);
    cycle();
    wr_valid = 0;
    #1;
    chk("t3_count", count, 4);
    for (int i = 0; i < 3; i++) cycle();
    #1;
    chk("t3_en7", en, 32'h80);
    chk("t3_d7", d, 32'h77);
    cycle();

    // duplicate-address bypass returns youngest; x0 lookup misses
    hold = 1;
    push(9, 32'hA);
    push(9, 32'hB);
    rs1_addr = 9; rs2_addr = 0;
    #1;
    chk("t4_hit1", rs1_hit, 1);
    chk("t4_data1", rs1_data, 32'hB);
    chk("t4_hit2", rs2_hit, 0);
    chk("t4_data2", rs2_data, 0);
    hold = 0;
    cycle();
    cycle();

    // write to x0 is accepted but not stored
    wr_valid = 1; wr_addr = 0; wr_data = 32'hFFFF;
    #1;
    chk("t5_ready", wr_ready, 1);
    cycle();
    wr_valid = 0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_en", en, 0);
    cycle();

    // reset discards pending entries
    hold = 1;
    for (int i = 1; i <= 3; i++) push(5'(i + 10), 32'h100 + i);
    rst = 1;
    cycle();
    rst = 0;
    hold = 0;
    #1;
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_en", en, 0);
    cycle();
    #1;
    chk("t6_en_after", en, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      wr_valid = ($urandom_range(0, 99) < 65);
      wr_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      wr_data  = $urandom;
      hold     = ($urandom_range(0, 99) < 35);
      rs1_addr = 5'($urandom_range(0, 5));
      rs2_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      cycle();
    end
    rst = 0; wr_valid = 0; hold = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_write_queue.md
Name: regbank_write_queue

Overview:
- Write-port front end that sits directly upstream of the parameterised register bank and drives the bank's `d` data input and one-hot `en` enables.
- Accepts write-back requests (register address plus data) through a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires one request per cycle into the bank unless the bank is held.
- Offers two bypass lookups, so read ports see pending, not-yet-committed values.

Parameters:
- DATA_LENGTH, 32, width of register data.
- REGS_QTY, 32, number of architectural registers; must be a power of two.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- ADDR_LENGTH, $clog2(REGS_QTY), register address width; local, not overridable.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request present.
- wr_ready  out  1  request accepted this cycle when high together with wr_valid.
- wr_addr  in  ADDR_LENGTH  destination register.
- wr_data  in  DATA_LENGTH  write data.
- hold  in  1  freezes retirement into the bank.
- en  out  REGS_QTY  one-hot write enable to the register bank.
- d  out  DATA_LENGTH  write data to the register bank.
- rs1_addr, rs2_addr  in  ADDR_LENGTH  bypass lookup addresses.
- rs1_hit, rs2_hit  out  1  a pending entry matches the lookup address.
- rs1_data, rs2_data  out  DATA_LENGTH  youngest pending matching data; 0 when there is no hit.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- empty  out  1  high when count == 0.

Behaviour:
- Reset: clk and rst as above; reset is synchronous and active-high. When rst=1 at a rising edge, head/tail pointers and count clear to 0 and all pending entries are discarded, including mid-operation ones. Resulting outputs: en=0, d=0, count=0, empty=1, rs*_hit=0, rs*_data=0, wr_ready=1.
- Pop condition: pop = !empty && !hold.
- Bank drive: en = pop ? (1 << head.addr) : 0, and d = pop ? head.data : 0. Both are combinational from the head entry, so the bank captures the entry on the same edge it is popped.
- Handshake: wr_ready = (count < DEPTH) || pop. It is combinational and may depend on hold. A push happens when wr_valid && wr_ready.
- Register x0: a request with wr_addr == 0 is accepted (wr_ready behaves as normal) but never stored; count is unchanged.
- Latency: a request accepted at edge E into an empty queue appears at the head after E. If hold=0 it is written to the bank at edge E+1. There is no combinational bypass from wr_* to en/d.
- Ordering: strictly FIFO; one pop per cycle at most.
- Simultaneous push and pop: count is unchanged, and this is legal even when full.
- Full (count == DEPTH) with no pop: wr_ready=0, and wr_valid is ignored.
- Pointers: head and tail wrap modulo DEPTH. count is updated as +1 (push only), −1 (pop only), or unchanged (both or neither).
- Bypass search: all occupied entries, including the head entry being popped this cycle. Priority goes to the youngest match (closest to tail). The search is combinational. The incoming wr_* request is not searched.
- Bypass on x0: rs*_addr == 0 gives hit=0 and data=0.
- Duplicate addresses: several pending writes to the same register are legal. All of them retire in order, and the bypass returns the youngest.
- hold=1: the queue still accepts requests until full; en stays 0.

Decomposition:
- Shared package: DATA_LENGTH and REGS_QTY defaults, ZERO_REG = 0, and a pending-entry struct {addr, data}.
- One sub-module: onehot_decoder_param (ADDR_LENGTH in, REGS_QTY out, with a gating enable) to generate `en`.
- FIFO storage and bypass search stay inline.

Test Plan:
- Reset, then a single write (addr=5, data=0xDEADBEEF) with hold=0 → next cycle en=0x00000020, d=0xDEADBEEF; the cycle after that en=0, empty=1.
- hold=1, push 4 writes (addr 1..4, data 0x11..0x44) → count=4, wr_ready=0, en=0. Release hold → 4 consecutive cycles with en=0x2,0x4,0x8,0x10 in order.
- Full queue, hold=0, wr_valid with addr=7 → wr_ready=1, count stays 4, and the addr-7 write retires 4 cycles later.
- Pending writes addr=9 with data 0xA then 0xB, rs1_addr=9 → rs1_hit=1, rs1_data=0xB. rs2_addr=0 → rs2_hit=0, rs2_data=0.
- Write to addr=0 with data 0xFFFF → accepted, count stays 0, en never asserts.
- hold=1, 3 entries pending, assert rst for one cycle → count=0, empty=1, en=0, and no retirement after hold is released.
